// File: rtl/data_demux_16x8_reg.sv
// Write-side 1:16 byte demultiplexer with registered slots, valid flags and
// write acknowledge; pairs with a 16:1 read mux to form a 16-entry register bank.
module data_demux_16x8_reg #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 A3,
  input  logic                 A2,
  input  logic                 A1,
  input  logic                 A0,
  input  logic [BIT_WIDTH-1:0] Input,
  output logic [BIT_WIDTH-1:0] D0,
  output logic [BIT_WIDTH-1:0] D1,
  output logic [BIT_WIDTH-1:0] D2,
  output logic [BIT_WIDTH-1:0] D3,
  output logic [BIT_WIDTH-1:0] D4,
  output logic [BIT_WIDTH-1:0] D5,
  output logic [BIT_WIDTH-1:0] D6,
  output logic [BIT_WIDTH-1:0] D7,
  output logic [BIT_WIDTH-1:0] D8,
  output logic [BIT_WIDTH-1:0] D9,
  output logic [BIT_WIDTH-1:0] DA,
  output logic [BIT_WIDTH-1:0] DB,
  output logic [BIT_WIDTH-1:0] DC,
  output logic [BIT_WIDTH-1:0] DD,
  output logic [BIT_WIDTH-1:0] DE,
  output logic [BIT_WIDTH-1:0] DF,
  output logic [15:0]          valid,
  output logic                 wr_ack,
  output logic [3:0]           last_a
);

  localparam int SLOTS = 16;

  // Identification parameters carry no function; the empty block only ties them in.
  if (UUID < 0 && $bits(NAME) == 0) begin : g_id_tag
  end

  logic [3:0]           addr;
  logic [BIT_WIDTH-1:0] slot_q [SLOTS];
  logic [BIT_WIDTH-1:0] slot_d [SLOTS];
  logic [SLOTS-1:0]     valid_q;
  logic [SLOTS-1:0]     valid_d;
  logic                 wr_ack_q;
  logic [3:0]           last_a_q;

  assign addr = {A3, A2, A1, A0};

  // Clear is applied before the write so a simultaneous write survives it.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (clr) begin
      for (int i = 0; i < SLOTS; i++) slot_d[i] = '0;
      valid_d = '0;
    end
    if (en) begin
      slot_d[addr]  = Input;
      valid_d[addr] = 1'b1;
    end
  end

  // The slot array is reset because the reset state of every slot is visible on the ports.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
      valid_q  <= '0;
      wr_ack_q <= 1'b0;
      last_a_q <= 4'd0;
    end else begin
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      wr_ack_q <= en;
      if (en) last_a_q <= addr;
    end
  end

  assign D0     = slot_q[0];
  assign D1     = slot_q[1];
  assign D2     = slot_q[2];
  assign D3     = slot_q[3];
  assign D4     = slot_q[4];
  assign D5     = slot_q[5];
  assign D6     = slot_q[6];
  assign D7     = slot_q[7];
  assign D8     = slot_q[8];
  assign D9     = slot_q[9];
  assign DA     = slot_q[10];
  assign DB     = slot_q[11];
  assign DC     = slot_q[12];
  assign DD     = slot_q[13];
  assign DE     = slot_q[14];
  assign DF     = slot_q[15];
  assign valid  = valid_q;
  assign wr_ack = wr_ack_q;
  assign last_a = last_a_q;

endmodule

// File: tb/tb_data_demux_16x8_reg.sv
// Self-checking bench for data_demux_16x8_reg: directed cases plus random
// writes compared against an array-based register-bank model.
module tb_data_demux_16x8_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] a   = 4'd0;
  logic [7:0] din = 8'd0;

  logic [7:0]  D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, DA, DB, DC, DD, DE, DF;
  logic [15:0] valid;
  logic        wr_ack;
  logic [3:0]  last_a;

  logic [7:0] d_obs [16];

  int total = 0;
  int bad   = 0;

  // Reference register bank
  logic [7:0]  m_d [16];
  logic [15:0] m_v;
  logic        m_ack;
  logic [3:0]  m_last;

  always #5 clk = ~clk;

  data_demux_16x8_reg #(.UUID(0), .NAME("tb"), .BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]), .Input(din),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .D8(D8), .D9(D9), .DA(DA), .DB(DB), .DC(DC), .DD(DD), .DE(DE), .DF(DF),
    .valid(valid), .wr_ack(wr_ack), .last_a(last_a)
  );

  // Read-side 16:1 mux view of the slot outputs
  assign d_obs[0]  = D0;  assign d_obs[1]  = D1;  assign d_obs[2]  = D2;  assign d_obs[3]  = D3;
  assign d_obs[4]  = D4;  assign d_obs[5]  = D5;  assign d_obs[6]  = D6;  assign d_obs[7]  = D7;
  assign d_obs[8]  = D8;  assign d_obs[9]  = D9;  assign d_obs[10] = DA;  assign d_obs[11] = DB;
  assign d_obs[12] = DC;  assign d_obs[13] = DD;  assign d_obs[14] = DE;  assign d_obs[15] = DF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_d[i] = 8'h00;
    m_v    = 16'h0000;
    m_ack  = 1'b0;
    m_last = 4'd0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_D%0h", tag, i), {24'd0, d_obs[i]}, {24'd0, m_d[i]});
    check({tag, "_valid"},  {16'd0, valid},  {16'd0, m_v});
    check({tag, "_wr_ack"}, {31'd0, wr_ack}, {31'd0, m_ack});
    check({tag, "_last_a"}, {28'd0, last_a}, {28'd0, m_last});
  endtask

  // Apply one cycle of inputs, advance past the edge, and update the model.
  task automatic step(input logic e, input logic c, input logic [3:0] addr, input logic [7:0] data);
    en = e; clr = c; a = addr; din = data;
    @(posedge clk);
    #1;
    if (c) begin
      for (int i = 0; i < 16; i++) m_d[i] = 8'h00;
      m_v = 16'h0000;
    end
    if (e) begin
      m_d[addr]  = data;
      m_v[addr]  = 1'b1;
      m_last     = addr;
    end
    m_ack = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset held with en=1: nothing may be written.
    en = 1'b1; a = 4'h2; din = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;

    // Single write
    step(1'b1, 1'b0, 4'h5, 8'hA7);
    check_all("single");
    check("single_D5", {24'd0, D5}, 32'hA7);
    check("single_valid", {16'd0, valid}, 32'h0020);
    step(1'b0, 1'b0, 4'h5, 8'h00);
    check_all("single_ack_drop");

    // Sweep all addresses back to back
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 8'(8'h10 + i));
      check($sformatf("sweep_ack_%0d", i), {31'd0, wr_ack}, 32'd1);
    end
    check_all("sweep");
    check("sweep_valid", {16'd0, valid}, 32'hFFFF);
    check("sweep_last", {28'd0, last_a}, 32'hF);

    // Overwrite, then hold with en=0
    step(1'b1, 1'b0, 4'hA, 8'h3C);
    step(1'b1, 1'b0, 4'hA, 8'hC3);
    check("overwrite_DA", {24'd0, DA}, 32'hC3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'h3, 8'hFF);
      check_all($sformatf("hold_%0d", i));
      check($sformatf("hold_D3_%0d", i), {24'd0, D3}, 32'h13);
    end

    // Clear with simultaneous write
    step(1'b1, 1'b1, 4'h9, 8'h55);
    check_all("clr_wr");
    check("clr_wr_valid", {16'd0, valid}, 32'h0200);
    check("clr_wr_D9", {24'd0, D9}, 32'h55);
    check("clr_wr_last", {28'd0, last_a}, 32'h9);

    // Clear alone keeps last_a, drops wr_ack
    step(1'b1, 1'b0, 4'h4, 8'h66);
    step(1'b0, 1'b1, 4'h7, 8'h77);
    check_all("clr_only");

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(3) != 0), ($urandom_range(19) == 0),
           4'($urandom_range(15)), 8'($urandom));
      check_all($sformatf("rand_%0d", n));
    end

    // Loopback: read mux at each address returns the last byte written there
    for (int k = 0; k < 16; k++)
      step(1'b1, 1'b0, 4'(k), 8'($urandom));
    for (int n = 0; n < 40; n++)
      step(1'b1, 1'b0, 4'($urandom_range(15)), 8'($urandom));
    for (int k = 0; k < 16; k++)
      check($sformatf("loopback_%0d", k), {24'd0, d_obs[k]}, {24'd0, m_d[k]});

    // Asynchronous reset mid-cycle, checked before the next edge
    step(1'b1, 1'b0, 4'hC, 8'h5A);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    en = 1'b1; a = 4'h1; din = 8'h99;
    @(posedge clk);
    #1;
    check_all("rst_mid_write");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 4'hE, 8'h42);
    check_all("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
